// File: rtl/screen_ctl.sv
// Game-flow sequencer: picks the screen shown by the draw stage, hit-tests mouse
// clicks against the choice boxes and changes screens only at the start of vblank.
module screen_ctl #(
  parameter logic [11:0] BLUE_X0        = 12'd300,
  parameter logic [11:0] BLUE_X1        = 12'd400,
  parameter logic [11:0] YELLOW_X0      = 12'd650,
  parameter logic [11:0] YELLOW_X1      = 12'd750,
  parameter logic [11:0] BOX_Y0         = 12'd450,
  parameter logic [11:0] BOX_Y1         = 12'd550,
  parameter int unsigned HOLD_FRAMES    = 60,
  parameter int unsigned TIMEOUT_FRAMES = 1800
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vblnk_in,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  input  logic        game_over,
  output logic        start_en,
  output logic        choice_en,
  output logic        game_en,
  output logic [1:0]  player_sel,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_TITLE  = 2'd0,
    ST_CHOICE = 2'd1,
    ST_PLAY   = 2'd2,
    ST_END    = 2'd3
  } state_t;

  localparam logic [10:0] TIMEOUT_LAST = 11'(TIMEOUT_FRAMES - 1);
  localparam logic [10:0] HOLD_MIN     = 11'(HOLD_FRAMES);

  logic        btn_s1;
  logic        btn_sync;
  logic        btn_q;
  logic        vblnk_q;
  logic        click_rise;
  logic        frame_tick;
  logic        click_pend;
  logic        go_pend;
  logic [11:0] cx;
  logic [11:0] cy;

  state_t      state;
  state_t      nxt_state;
  logic [1:0]  nxt_sel;
  logic [10:0] frame_cnt;
  logic        armed;
  logic        click_ok;
  logic        blue_hit;
  logic        yellow_hit;
  logic        y_in;

  assign click_rise = btn_sync & ~btn_q;
  assign frame_tick = vblnk_in & ~vblnk_q;
  assign click_ok   = armed & click_pend;

  assign y_in       = (cy >= BOX_Y0) && (cy <= BOX_Y1);
  assign blue_hit   = y_in && (cx >= BLUE_X0)   && (cx <= BLUE_X1);
  assign yellow_hit = y_in && (cx >= YELLOW_X0) && (cx <= YELLOW_X1);

  assign state_o = state;

  // Button synchronizer, edge detect and event capture between frame ticks
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      btn_s1     <= 1'b0;
      btn_sync   <= 1'b0;
      btn_q      <= 1'b0;
      vblnk_q    <= 1'b0;
      click_pend <= 1'b0;
      go_pend    <= 1'b0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      btn_s1   <= mouse_left;
      btn_sync <= btn_s1;
      btn_q    <= btn_sync;
      vblnk_q  <= vblnk_in;
      // Pending flags are consumed on the tick; an event landing on that same
      // cycle re-arms the flag so it is not lost.
      if (frame_tick) begin
        click_pend <= click_rise;
        go_pend    <= game_over;
        if (click_rise) begin
          cx <= mouse_xpos;
          cy <= mouse_ypos;
        end
      end else begin
        if (click_rise && !click_pend) begin
          click_pend <= 1'b1;
          cx         <= mouse_xpos;
          cy         <= mouse_ypos;
        end
        if (game_over) begin
          go_pend <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    nxt_state = state;
    nxt_sel   = player_sel;
    case (state)
      ST_TITLE: begin
        if (click_ok) begin
          nxt_state = ST_CHOICE;
        end
      end
      ST_CHOICE: begin
        if (click_ok && blue_hit) begin
          nxt_state = ST_PLAY;
          nxt_sel   = 2'b01;
        end else if (click_ok && yellow_hit) begin
          nxt_state = ST_PLAY;
          nxt_sel   = 2'b10;
        end else if (frame_cnt == TIMEOUT_LAST) begin
          nxt_state = ST_TITLE;
        end
      end
      ST_PLAY: begin
        if (go_pend) begin
          nxt_state = ST_END;
        end
      end
      ST_END: begin
        if (click_ok && (frame_cnt >= HOLD_MIN)) begin
          nxt_state = ST_TITLE;
          nxt_sel   = '0;
        end
      end
      default: nxt_state = ST_TITLE;
    endcase
  end

  // Outputs are decoded from the next state so they move on the tick edge itself
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_TITLE;
      frame_cnt  <= '0;
      armed      <= 1'b0;
      player_sel <= '0;
      start_en   <= 1'b0;
      choice_en  <= 1'b0;
      game_en    <= 1'b0;
    end else if (frame_tick) begin
      state      <= nxt_state;
      player_sel <= nxt_sel;
      start_en   <= (nxt_state != ST_TITLE);
      choice_en  <= (nxt_state == ST_CHOICE);
      game_en    <= (nxt_state == ST_PLAY);
      if (nxt_state != state) begin
        frame_cnt <= '0;
        armed     <= 1'b0;
      end else begin
        if (frame_cnt != '1) begin
          frame_cnt <= frame_cnt + 11'd1;
        end
        if (!btn_sync) begin
          armed <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_screen_ctl.sv
// Self-checking bench for screen_ctl: directed flow plus randomized frames,
// checked against a frame-level reference model of the game flow.
module tb_screen_ctl;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        vblnk_in;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic        mouse_left;
  logic        game_over;
  logic        start_en;
  logic        choice_en;
  logic        game_en;
  logic [1:0]  player_sel;
  logic [1:0]  state_o;

  screen_ctl #(
    .HOLD_FRAMES   (60),
    .TIMEOUT_FRAMES(1800)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .vblnk_in  (vblnk_in),
    .mouse_xpos(mouse_xpos),
    .mouse_ypos(mouse_ypos),
    .mouse_left(mouse_left),
    .game_over (game_over),
    .start_en  (start_en),
    .choice_en (choice_en),
    .game_en   (game_en),
    .player_sel(player_sel),
    .state_o   (state_o)
  );

  always #5 pclk = ~pclk;

  // Reference model: 0 TITLE, 1 CHOICE, 2 PLAY, 3 END
  int m_state, m_sel, m_cnt, m_px, m_py;
  bit m_armed, m_pend, m_go, m_btn;
  int passed = 0;
  int failed = 0;
  int total  = 0;

  function automatic bit in_box(int x, int y, int x0, int x1);
    return (x >= x0) && (x <= x1) && (y >= 450) && (y <= 550);
  endfunction

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs(input string tag);
    chk({tag, ".state"},  12'(state_o),    12'(m_state));
    chk({tag, ".start"},  12'(start_en),   12'(m_state != 0));
    chk({tag, ".choice"}, 12'(choice_en),  12'(m_state == 1));
    chk({tag, ".game"},   12'(game_en),    12'(m_state == 2));
    chk({tag, ".sel"},    12'(player_sel), 12'(m_sel));
  endtask

  task automatic model_reset();
    m_state = 0; m_sel = 0; m_cnt = 0; m_armed = 0;
    m_pend = 0;  m_go = 0;  m_btn = 0; m_px = 0; m_py = 0;
  endtask

  task automatic model_tick();
    bit valid;
    int ns, nsel;
    valid = m_armed && m_pend;
    ns    = m_state;
    nsel  = m_sel;
    if (m_state == 0) begin
      if (valid) ns = 1;
    end else if (m_state == 1) begin
      if (valid && in_box(m_px, m_py, 300, 400)) begin
        ns = 2; nsel = 1;
      end else if (valid && in_box(m_px, m_py, 650, 750)) begin
        ns = 2; nsel = 2;
      end else if (m_cnt + 1 == 1800) begin
        ns = 0;
      end
    end else if (m_state == 2) begin
      if (m_go) ns = 3;
    end else begin
      if (valid && m_cnt >= 60) begin
        ns = 0; nsel = 0;
      end
    end
    if (ns != m_state) begin
      m_cnt = 0; m_armed = 0;
    end else begin
      if (m_cnt < 2047) m_cnt++;
      if (!m_btn) m_armed = 1;
    end
    m_state = ns; m_sel = nsel; m_pend = 0; m_go = 0;
  endtask

  task automatic tick(input string tag);
    @(negedge pclk);
    vblnk_in = 1'b1;
    model_tick();
    @(posedge pclk);
    #1 chk_outputs(tag);
    @(negedge pclk);
    @(negedge pclk);
    vblnk_in = 1'b0;
    @(negedge pclk);
  endtask

  task automatic press(input int x, input int y);
    if (!m_btn) begin
      @(negedge pclk);
      mouse_xpos = 12'(x);
      mouse_ypos = 12'(y);
      mouse_left = 1'b1;
      if (!m_pend) begin
        m_pend = 1; m_px = x; m_py = y;
      end
      m_btn = 1;
      repeat (4) @(negedge pclk);
      mouse_xpos = 12'($urandom);
      mouse_ypos = 12'($urandom);
    end
  endtask

  task automatic release_btn();
    @(negedge pclk);
    mouse_left = 1'b0;
    m_btn = 0;
    repeat (3) @(negedge pclk);
  endtask

  task automatic click(input int x, input int y);
    press(x, y);
    release_btn();
  endtask

  task automatic go_pulse();
    @(negedge pclk);
    game_over = 1'b1;
    m_go = 1;
    @(negedge pclk);
    game_over = 1'b0;
  endtask

  // From PLAY: finish the game, sit out the hold period, click back to TITLE
  task automatic play_to_title();
    go_pulse();
    tick("to_end");
    while (m_cnt < 60) tick("end_wait");
    click(5, 5);
    tick("end_exit");
  endtask

  task automatic rand_click();
    int x, y;
    case ($urandom_range(0, 2))
      0:       x = $urandom_range(290, 410);
      1:       x = $urandom_range(640, 760);
      default: x = $urandom_range(0, 4095);
    endcase
    y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4095) : $urandom_range(440, 560);
    click(x, y);
  endtask

  initial begin
    rst_n = 1'b0; vblnk_in = 1'b0; mouse_left = 1'b0; game_over = 1'b0;
    mouse_xpos = '0; mouse_ypos = '0;
    model_reset();
    repeat (3) @(negedge pclk);
    chk_outputs("reset");
    @(negedge pclk);
    rst_n = 1'b1;

    // Button low for two frames, then a click anywhere
    tick("idle1");
    tick("idle2");
    click(10, 10);
    tick("title_to_choice");
    chk("choice_start_en", 12'(start_en), 12'd1);

    tick("choice_arm");
    click(300, 450);
    tick("blue_corner");
    chk("blue_sel", 12'(player_sel), 12'd1);

    // End screen hold: click at count 59 ignored, at 60 accepted
    go_pulse();
    click(350, 500);
    tick("go_and_click");
    chk("end_state", 12'(state_o), 12'd3);
    while (m_cnt < 59) tick("end_hold");
    click(20, 20);
    tick("end_click59");
    chk("end_click59_stays", 12'(state_o), 12'd3);
    click(20, 20);
    tick("end_click60");
    chk("end_click60_title", 12'(state_o), 12'd0);

    // Just outside yellow, then yellow far corner
    tick("title_arm");
    click(10, 10);
    tick("to_choice2");
    tick("choice_arm2");
    click(751, 500);
    tick("yellow_miss");
    chk("yellow_miss_state", 12'(state_o), 12'd1);
    click(750, 550);
    tick("yellow_corner");
    chk("yellow_sel", 12'(player_sel), 12'd2);

    // Button held across TITLE->CHOICE must not select a box
    play_to_title();
    tick("title_arm3");
    press(350, 500);
    tick("held_to_choice");
    tick("held1");
    tick("held2");
    release_btn();
    press(350, 500);
    tick("unarmed_click");
    chk("unarmed_stays", 12'(state_o), 12'd1);
    release_btn();
    tick("rearm");
    click(350, 500);
    tick("rearmed_click");
    chk("rearmed_play", 12'(state_o), 12'd2);

    // Timeout after 1800 idle ticks in CHOICE
    play_to_title();
    tick("title_arm4");
    click(1, 1);
    tick("to_choice_to");
    repeat (1799) tick("timeout_wait");
    chk("timeout_pre", 12'(state_o), 12'd1);
    tick("timeout_hit");
    chk("timeout_title", 12'(state_o), 12'd0);

    // Box click on the timeout tick wins
    tick("title_arm5");
    click(1, 1);
    tick("to_choice_hit");
    repeat (1799) tick("timeout_wait2");
    click(700, 500);
    tick("hit_beats_timeout");
    chk("hit_beats_timeout_state", 12'(state_o), 12'd2);

    // Randomized frames
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rand_click();
        4:          go_pulse();
        5:          press($urandom_range(280, 770), $urandom_range(440, 560));
        6:          if (m_btn) release_btn();
        default:    ;
      endcase
      tick("rand");
    end
    if (m_btn) release_btn();

    // Asynchronous reset mid-line while in PLAY
    if (m_state != 2) begin
      if (m_state == 3) begin
        while (m_cnt < 60) tick("r_end");
        click(5, 5);
        tick("r_exit");
      end
      if (m_state == 1) begin
        repeat (2) tick("r_choice");
        click(350, 500);
        tick("r_play");
      end else begin
        tick("r_arm");
        click(5, 5);
        tick("r_choice2");
        tick("r_arm2");
        click(350, 500);
        tick("r_play2");
      end
    end
    chk("pre_reset_play", 12'(state_o), 12'd2);
    @(posedge pclk);
    #3 rst_n = 1'b0;
    model_reset();
    #1 chk_outputs("async_reset");
    @(negedge pclk);
    rst_n = 1'b1;
    tick("post_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
